// File: rtl/toggle_pulse_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_pulse_rx_if
//  Purpose  : Signal bundle for the toggle-pulse receiver. Carries the
//             incoming toggle line, the enable/clear controls and the
//             pending-event valid/ready handshake.
//  Modports : slave  - the receiver (drives level/pulse/handshake/status)
//             master - the environment (drives t_in, en, ev_ready, clr_ovf)
//  Revision : 1.0  initial release
// ============================================================================
interface toggle_pulse_rx_if #(
  parameter int PEND_W = 4,
  parameter int CNT_W  = 8
);
  logic              t_in;
  logic              en;
  logic              ev_ready;
  logic              clr_ovf;
  logic              level;
  logic              pulse;
  logic              ev_valid;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  ev_count;
  logic              overflow;

  modport master (
    output t_in, en, ev_ready, clr_ovf,
    input  level, pulse, ev_valid, pending, ev_count, overflow
  );

  modport slave (
    input  t_in, en, ev_ready, clr_ovf,
    output level, pulse, ev_valid, pending, ev_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/toggle_pulse_rx.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_pulse_rx
//  Purpose  : Consumer end of a toggle-encoded event link. Synchronises the
//             remote toggle line, turns each level change into a one-cycle
//             pulse, and tracks a saturating pending-event credit (valid/ready),
//             a wrapping total-event count and a sticky overflow flag.
//  Ports    : clk    - sole clock, rising edge
//             reset  - synchronous, active-high
//             bus    - toggle_pulse_rx_if.slave
//                      in : t_in (async), en, ev_ready, clr_ovf
//                      out: level, pulse, ev_valid, pending, ev_count, overflow
//  Revision : 1.0  initial release
// ============================================================================
module toggle_pulse_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  toggle_pulse_rx_if.slave   bus
);

  localparam int                c_prime_w    = $clog2(SYNC_STAGES + 1);
  localparam logic [c_prime_w-1:0] c_prime_last = c_prime_w'(SYNC_STAGES);
  localparam logic [PEND_W-1:0] c_pend_max   = '1;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_prime_w-1:0]   r_prime_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_pulse;
  logic                   r_ev_valid;
  logic [PEND_W-1:0]      r_pending;
  logic [CNT_W-1:0]       r_ev_count;
  logic                   r_overflow;

  logic                   w_level;
  logic                   w_edge;
  logic                   w_event;
  logic                   w_accept;
  logic [PEND_W-1:0]      w_pend_nxt;
  logic                   w_ovf_set;

  assign w_level  = r_sync[SYNC_STAGES-1];
  assign w_edge   = w_level ^ r_last;
  // Only RUN with en still high accepts edges; the cycle that drops en is
  // already gated off even though the state change to HOLD is registered.
  assign w_event  = (r_state == RUN) && bus.en && w_edge;
  assign w_accept = (r_pending != '0) && bus.ev_ready;

  // Credit update. An event and an accept together cancel, so a full
  // counter is not considered overflowed in that case.
  always_comb begin
    w_pend_nxt = r_pending;
    w_ovf_set  = 1'b0;
    if (w_event && !w_accept) begin
      if (r_pending == c_pend_max) begin
        w_ovf_set = 1'b1;
      end else begin
        w_pend_nxt = r_pending + 1'b1;
      end
    end else if (!w_event && w_accept) begin
      w_pend_nxt = r_pending - 1'b1;
    end
  end

  // Synchroniser and history flop run in every state so that edges seen
  // while primed or on hold are absorbed rather than replayed later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.t_in};
      r_last <= w_level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PRIME;
      r_prime_cnt <= '0;
    end else begin
      case (r_state)
        PRIME: begin
          // SYNC_STAGES+1 cycles lets the synchroniser and the history
          // flop both reflect the real line level before edges count.
          if (r_prime_cnt == c_prime_last) begin
            r_state <= bus.en ? RUN : HOLD;
          end else begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!bus.en) r_state <= HOLD;
        end
        HOLD: begin
          if (bus.en) r_state <= RUN;
        end
        default: r_state <= PRIME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse    <= 1'b0;
      r_ev_valid <= 1'b0;
      r_pending  <= '0;
      r_ev_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pulse    <= w_event;
      r_pending  <= w_pend_nxt;
      r_ev_valid <= (w_pend_nxt != '0);
      if (w_event) r_ev_count <= r_ev_count + 1'b1;
      // Set has priority over a simultaneous clear.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.level    = w_level;
  assign bus.pulse    = r_pulse;
  assign bus.ev_valid = r_ev_valid;
  assign bus.pending  = r_pending;
  assign bus.ev_count = r_ev_count;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
